// File: rtl/approx_mon_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
package approx_mon_pkg;

  // Monitor control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Default operand width of the adders under characterisation.
  localparam int DEF_WIDTH = 16;

  // Number of index bits needed to count one window of samples.
  function automatic int lw_of(input int window);
    return $clog2(window);
  endfunction

  // Error distance is one bit wider than the operands (carry-out included).
  function automatic int ed_width(input int width);
    return width + 1;
  endfunction

  localparam int ED_W = ed_width(DEF_WIDTH);

endpackage

// File: rtl/approx_ed_calc.sv
// Combinational exact-sum and absolute error distance between the exact
// and approximate adder results.
module approx_ed_calc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   approx,
  output logic [WIDTH:0]   ed
);

  logic [WIDTH:0] exact;

  // Exact sum with carry-out, then unsigned |exact - approx|.
  // NOTE: every combinational output is assigned on every path, so no latch is inferred.
  always_comb begin
    exact = {1'b0, a} + {1'b0, b};
    ed    = (exact >= approx) ? (exact - approx) : (approx - exact);
  end

endmodule

// File: rtl/approx_err_monitor.sv
// Windowed error-metric collector for approximate adders: per-sample error
// distance, then ED sum, MAE, WCE and error count reported every WINDOW
// samples over a valid/ready handshake.
module approx_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WINDOW = 256,
  localparam int LW    = lw_of(WINDOW),
  localparam int EDW   = ed_width(WIDTH),
  localparam int SW    = EDW + LW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SW-1:0]    out_sum_ed,
  output logic [EDW-1:0]   out_mae,
  output logic [EDW-1:0]   out_wce,
  output logic [LW:0]      out_err_cnt
);

  state_t          state, state_n;
  logic [LW-1:0]   cnt;
  logic            ed_valid;
  logic [EDW-1:0]  ed_q;
  logic [EDW-1:0]  ed;
  logic            accept;
  logic            handshake;
  logic            last;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == REPORT);
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;
  assign last      = (cnt == LW'(WINDOW - 1));
  assign out_mae   = out_sum_ed[SW-1:LW];

  approx_ed_calc #(.WIDTH(WIDTH)) u_ed (
    .a      (in_a),
    .b      (in_b),
    .approx (in_approx),
    .ed     (ed)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode; clear overrides everything, including a report handshake.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = ACCUM;
      ACCUM:   if (accept && last) state_n = DRAIN;
      DRAIN:   state_n = REPORT;
      REPORT:  if (out_ready) state_n = ACCUM;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = ACCUM;
  end

  // Sample counter; wraps to zero on the last sample of a window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (accept) cnt <= cnt + 1'b1;
  end

  // Stage 1: register the error distance of each accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ed_valid <= 1'b0;
      ed_q     <= '0;
    end else if (clear) begin
      ed_valid <= 1'b0;
      ed_q     <= '0;
    end else begin
      ed_valid <= accept;
      if (accept) ed_q <= ed;
    end
  end

  // Stage 2: accumulate; registers double as the report outputs and are
  // zeroed when the report is taken or the window is aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum_ed  <= '0;
      out_wce     <= '0;
      out_err_cnt <= '0;
    end else if (clear || handshake) begin
      out_sum_ed  <= '0;
      out_wce     <= '0;
      out_err_cnt <= '0;
    end else if (ed_valid) begin
      out_sum_ed  <= out_sum_ed + SW'(ed_q);
      if (ed_q > out_wce) out_wce <= ed_q;
      if (ed_q != '0)     out_err_cnt <= out_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed self-checking bench for approx_err_monitor (WIDTH=16, WINDOW=4).
module tb_approx_err_monitor;

  localparam int WIDTH  = 16;
  localparam int WINDOW = 4;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [16:0] in_approx;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_sum_ed;
  logic [16:0] out_mae;
  logic [16:0] out_wce;
  logic [2:0]  out_err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  approx_err_monitor #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_approx   (in_approx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum_ed  (out_sum_ed),
    .out_mae     (out_mae),
    .out_wce     (out_wce),
    .out_err_cnt (out_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: present one sample, let the next rising edge
  // take it, and return at the following falling edge with in_valid low.
  task automatic send(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [16:0] x);
    in_a      = a;
    in_b      = b;
    in_approx = x;
    in_valid  = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_report(input string tag, input logic [31:0] sum, input logic [31:0] mae,
                              input logic [31:0] wce, input logic [31:0] cnt);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum_ed"},    32'(out_sum_ed), sum);
    check({tag, "_mae"},       32'(out_mae), mae);
    check({tag, "_wce"},       32'(out_wce), wce);
    check({tag, "_err_cnt"},   32'(out_err_cnt), cnt);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_hs_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_hs_in_ready"},  32'(in_ready), 32'd1);
    check({tag, "_hs_sum_zero"},  32'(out_sum_ed), 32'd0);
  endtask

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_approx = '0;
    out_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum_ed",    32'(out_sum_ed), 32'd0);
    check("rst_mae",       32'(out_mae), 32'd0);
    check("rst_wce",       32'(out_wce), 32'd0);
    check("rst_err_cnt",   32'(out_err_cnt), 32'd0);
    rst_n = 1'b1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("accum_in_ready", 32'(in_ready), 32'd1);

    // Window 1: EDs 1, 0, 0, 2.
    send("w1_s0", 16'd3, 16'd1, 17'h3);
    send("w1_s1", 16'd0, 16'd0, 17'h0);
    send("w1_s2", 16'd5, 16'd5, 17'hA);
    send("w1_s3", 16'hFFFF, 16'hFFFF, 17'h1FFFC);
    check("w1_drain_out_valid", 32'(out_valid), 32'd0);
    check("w1_drain_in_ready",  32'(in_ready), 32'd0);
    @(negedge clk);
    check_report("w1", 32'd3, 32'd0, 32'd2, 32'd2);
    handshake("w1");

    // Window 2: approximate result above exact (exact 1, approx 0x1FFFF).
    send("w2_s0", 16'd1, 16'd0, 17'h1FFFF);
    send("w2_s1", 16'd2, 16'd3, 17'h5);
    send("w2_s2", 16'h8000, 16'h8000, 17'h10000);
    send("w2_s3", 16'd7, 16'd9, 17'h10);
    @(negedge clk);
    check_report("w2", 32'h1FFFE, 32'h7FFF, 32'h1FFFE, 32'd1);

    // Backpressure: hold a sample (ED 7) on the input for 10 cycles.
    in_a      = 16'd7;
    in_b      = 16'd0;
    in_approx = 17'h0;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready), 32'd0);
      check("bp_sum_ed",    32'(out_sum_ed), 32'h1FFFE);
      check("bp_wce",       32'(out_wce), 32'h1FFFE);
    end
    handshake("w2");
    // The held sample is taken on the edge after the handshake edge.
    send("w3_s0", 16'd7, 16'd0, 17'h0);
    send("w3_s1", 16'd2, 16'd2, 17'h4);
    send("w3_s2", 16'd1, 16'd1, 17'h2);
    send("w3_s3", 16'd9, 16'd0, 17'h9);
    check("w3_drain_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_report("w3", 32'd7, 32'd1, 32'd7, 32'd1);
    handshake("w3");

    // Clear mid-window: two erroneous samples, clear alongside a third.
    send("w4_s0", 16'd1, 16'd1, 17'h0);
    send("w4_s1", 16'd2, 16'd2, 17'h0);
    check("w4_partial_sum", 32'(out_sum_ed), 32'd2);
    clear = 1'b1;
    send("w4_s2", 16'd3, 16'd3, 17'h0);
    clear = 1'b0;
    check("clr_sum_ed",   32'(out_sum_ed), 32'd0);
    check("clr_in_ready", 32'(in_ready), 32'd1);
    send("w5_s0", 16'd10, 16'd20, 17'd30);
    send("w5_s1", 16'd0, 16'd0, 17'h0);
    send("w5_s2", 16'hFFFF, 16'd1, 17'h10000);
    send("w5_s3", 16'd100, 16'd1, 17'd101);
    check("w5_drain_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_report("w5", 32'd0, 32'd0, 32'd0, 32'd0);

    // Asynchronous reset while the report is pending.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready",  32'(in_ready), 32'd0);
    check("arst_sum_ed",    32'(out_sum_ed), 32'd0);
    check("arst_wce",       32'(out_wce), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("arst_idle_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("arst_accum_in_ready", 32'(in_ready), 32'd1);
    check("arst_accum_out_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/approx_err_monitor.md
# approx_err_monitor

Streaming error-metric collector placed directly downstream of the 16-bit approximate ripple-carry adders. Each accepted sample carries both operands and the approximate sum. The block computes the exact sum, the error distance (ED) and windowed statistics. After every WINDOW samples it reports the ED sum, MAE, worst-case error (WCE) and error count through a valid/ready handshake, which lets a simulation or emulation harness characterise an adder variant at speed.

## Interface
- WIDTH, 16: operand width; the approximate sum is WIDTH+1 bits.
- WINDOW, 256: samples per report; power of two, ≥2. LW = log2(WINDOW).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- clear  in  1  synchronous abort of the current window; highest synchronous priority.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accept; high only in ACCUM.
- in_a, in_b  in  WIDTH  operands.
- in_approx  in  WIDTH+1  approximate adder output.
- out_valid  out  1  report valid.
- out_ready  in  1  report accept.
- out_sum_ed  out  WIDTH+1+LW  ED sum over the window.
- out_mae  out  WIDTH+1  out_sum_ed >> LW, truncated.
- out_wce  out  WIDTH+1  maximum ED in the window.
- out_err_cnt  out  LW+1  count of samples with ED ≠ 0.

## Operation
- States:
  - IDLE: entered on reset. Moves to ACCUM unconditionally on the next edge.
  - ACCUM: counts accepted samples. Moves to DRAIN on the edge that accepts sample number WINDOW.
  - DRAIN: stays one cycle, then moves to REPORT.
  - REPORT: holds until out_valid & out_ready, then moves to ACCUM with all accumulators zeroed.
- Stage 1, on acceptance (in_valid & in_ready): compute exact = in_a + in_b (WIDTH+1 bits, no overflow). Register ED = |exact − in_approx| (WIDTH+1 bits, unsigned) and an ed_valid flag.
- Stage 2, on ed_valid:
  - sum += ED.
  - wce = max(wce, ED).
  - err_cnt += (ED ≠ 0).
  - None of these can overflow at the stated widths.
- in_ready = (state == ACCUM), decoded combinationally from the state register.
- out_valid = (state == REPORT). All report outputs are driven from registers and stay stable while out_valid is high.
- in_valid is ignored outside ACCUM. out_ready is ignored outside REPORT.
- clear, in any state: zero the accumulators, sample counter and ed_valid (any in-flight sample is dropped), then go to ACCUM. The report is discarded.
- Reset: state IDLE, in_ready 0, out_valid 0, and every accumulator and output 0.

## Timing
- Let edge t accept the final sample of a window. Then:
  - DRAIN runs in the cycle after edge t.
  - The edge at t+1 updates the accumulators.
  - out_valid is high from after edge t+1, a latency of 2 edges.
- in_ready is low from after edge t until the report handshake edge. The earliest next-window acceptance is the edge after that handshake edge.
- Back-to-back samples are accepted at one per cycle throughout ACCUM.
- Asynchronous reset mid-window or mid-REPORT drops out_valid and in_ready immediately, with no handshake.
- When clear and the report handshake occur in the same cycle, clear wins. The result is the same either way: state ACCUM, accumulators zero.

## Structure
- Package approx_mon_pkg holds:
  - the state enum {IDLE, ACCUM, DRAIN, REPORT};
  - a clog2-based width function for LW;
  - a localparam for the ED width (WIDTH+1).
- Sub-module approx_ed_calc: combinational exact-sum and absolute-difference unit, parameterised by WIDTH. It is reusable by the formal harnesses.
- The top level contains the FSM, the stage-1 register, the accumulators and the sample counter.

## Test plan
All scenarios use WIDTH=16, WINDOW=4.
- Reset:
  - Stimulus: hold rst_n low, then release.
  - Required: all outputs 0 while rst_n is low; in_ready 0 in the first cycle after release and 1 from the second cycle.
- One full window:
  - Stimulus: samples (a, b, approx) = (3, 1, 0x3), (0, 0, 0x0), (5, 5, 0xA), (0xFFFF, 0xFFFF, 0x1FFFC) on consecutive cycles.
  - Required: out_valid 2 edges after the 4th accept, with sum_ed = 3, mae = 0, wce = 2, err_cnt = 2.
- Approximate result above exact:
  - Stimulus: (1, 0, 0x1FFFF) plus three exact samples.
  - Required: wce = 0x1FFFE, sum_ed = 0x1FFFE, mae = 0x7FFF, err_cnt = 1.
- Report backpressure:
  - Stimulus: out_ready low for 10 cycles while in_valid is held high.
  - Required: report outputs stable and in_ready 0 throughout. After the handshake, the next window starts from zero and its first sample is accepted one edge later.
- Clear mid-window:
  - Stimulus: accept 2 erroneous samples, assert clear in the same cycle as a 3rd accept, then send 4 exact samples.
  - Required: the next report is sum_ed = 0, err_cnt = 0, wce = 0.
- Asynchronous reset during REPORT:
  - Stimulus: pull rst_n low while out_valid is high.
  - Required: out_valid falls without a clock edge. After release, the block re-enters ACCUM through IDLE.
